// File: rtl/fused_block_ctrl_param_if.sv
// Bus bundle between the fused-block controller and its global/fused BRAMs.
// master: controller side; slave: host/BRAM side.
interface fused_block_ctrl_param_if #(
    parameter int ADDR_W    = 32,
    parameter int N_BANK_L1 = 16,
    parameter int N_BANK_L2 = 4
);
    localparam int NB = N_BANK_L1 + N_BANK_L2 + 1;

    logic              start;
    logic              busy;
    logic              done;
    logic              compute_en;
    logic [ADDR_W-1:0] rd_addr_global;
    logic              rd_en_global;
    logic [ADDR_W-1:0] wr_addr_global;
    logic              we_global;
    logic [ADDR_W-1:0] wr_addr_fused;
    logic [NB-1:0]     we_fused;
    logic [ADDR_W-1:0] base_addr_IFM;
    logic [ADDR_W-1:0] base_addr_W1;
    logic [ADDR_W-1:0] base_addr_W2;
    logic [ADDR_W-1:0] base_addr_OFM;
    logic [ADDR_W-1:0] size_IFM;
    logic [ADDR_W-1:0] size_W1;
    logic [ADDR_W-1:0] size_W2;
    logic [ADDR_W-1:0] size_OFM;
    logic              valid_layer2;

    modport master (
        input  start, valid_layer2,
        input  base_addr_IFM, base_addr_W1, base_addr_W2, base_addr_OFM,
        input  size_IFM, size_W1, size_W2, size_OFM,
        output busy, done, compute_en,
        output rd_addr_global, rd_en_global, wr_addr_global, we_global,
        output wr_addr_fused, we_fused
    );

    modport slave (
        output start, valid_layer2,
        output base_addr_IFM, base_addr_W1, base_addr_W2, base_addr_OFM,
        output size_IFM, size_W1, size_W2, size_OFM,
        input  busy, done, compute_en,
        input  rd_addr_global, rd_en_global, wr_addr_global, we_global,
        input  wr_addr_fused, we_fused
    );
endinterface

// File: rtl/fused_block_ctrl_param.sv
// Streams W1/W2/IFM words from global BRAM into one-hot fused banks, then writes OFM words back.
// Latency: fused write trails its global read by RD_LAT cycles; OFM write one cycle after valid_layer2.
// Backpressure: none; reads issue every load cycle, OFM pulses beyond the job's count are dropped.
module fused_block_ctrl_param #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4,
    parameter int N_BANK_L1  = 16,
    parameter int N_BANK_L2  = 4,
    parameter int RD_LAT     = 1,
    parameter int FILL_WORDS = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    fused_block_ctrl_param_if.master bus
);
    localparam int NB = N_BANK_L1 + N_BANK_L2 + 1;
    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] WB     = ADDR_W'(WORD_BYTES);
    localparam logic [ADDR_W-1:0] DIV_W1 = ADDR_W'(WORD_BYTES * N_BANK_L1);
    localparam logic [ADDR_W-1:0] DIV_W2 = ADDR_W'(WORD_BYTES * N_BANK_L2);
    localparam logic [ADDR_W-1:0] FILL_A = ADDR_W'(FILL_WORDS);

    typedef enum logic [2:0] {IDLE, LOAD_W1, LOAD_W2, STREAM_IFM, DRAIN, DONE} state_t;
    state_t state;

    logic [ADDR_W-1:0] base_ifm, base_w1, base_w2, base_ofm;
    logic [ADDR_W-1:0] w1pb, w2pb, ni, no;
    logic [ADDR_W-1:0] word_cnt, bank_cnt, rd_off, fused_off;
    logic [ADDR_W-1:0] ofm_cnt, ofm_off, ifm_wr_cnt;

    // Fused-side tag travelling with each read; zero tag means no write.
    logic [ADDR_W-1:0] tag_addr;
    logic [NB-1:0]     tag_oh;
    logic [ADDR_W-1:0] pipe_addr [RD_LAT];
    logic [NB-1:0]     pipe_oh   [RD_LAT];

    logic [ADDR_W-1:0] cur_base, cur_pw, cur_last_bank, cur_bank0;
    state_t            cur_next;
    logic              phase_end;
    logic              pending;

    always_comb begin
        cur_base      = base_w1;
        cur_pw        = w1pb;
        cur_last_bank = ADDR_W'(N_BANK_L1 - 1);
        cur_bank0     = '0;
        cur_next      = LOAD_W2;
        case (state)
            LOAD_W2: begin
                cur_base      = base_w2;
                cur_pw        = w2pb;
                cur_last_bank = ADDR_W'(N_BANK_L2 - 1);
                cur_bank0     = ADDR_W'(N_BANK_L1);
                cur_next      = STREAM_IFM;
            end
            STREAM_IFM: begin
                cur_base      = base_ifm;
                cur_pw        = ni;
                cur_last_bank = '0;
                cur_bank0     = ADDR_W'(N_BANK_L1 + N_BANK_L2);
                cur_next      = DRAIN;
            end
            default: ;
        endcase
        phase_end = (cur_pw == '0) ||
                    ((word_cnt == cur_pw - ONE) && (bank_cnt == cur_last_bank));
    end

    always_comb begin
        pending = bus.rd_en_global;
        for (int i = 0; i < RD_LAT; i++) begin
            pending = pending | (pipe_oh[i] != '0);
        end
    end

    assign bus.wr_addr_fused = pipe_addr[RD_LAT-1];
    assign bus.we_fused      = pipe_oh[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_addr[i] <= '0;
                pipe_oh[i]   <= '0;
            end
        end else begin
            pipe_addr[0] <= tag_addr;
            pipe_oh[0]   <= tag_oh;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_addr[i] <= pipe_addr[i-1];
                pipe_oh[i]   <= pipe_oh[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state              <= IDLE;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.compute_en     <= 1'b0;
            bus.rd_en_global   <= 1'b0;
            bus.rd_addr_global <= '0;
            bus.we_global      <= 1'b0;
            bus.wr_addr_global <= '0;
            tag_addr           <= '0;
            tag_oh             <= '0;
            base_ifm           <= '0;
            base_w1            <= '0;
            base_w2            <= '0;
            base_ofm           <= '0;
            w1pb               <= '0;
            w2pb               <= '0;
            ni                 <= '0;
            no                 <= '0;
            word_cnt           <= '0;
            bank_cnt           <= '0;
            rd_off             <= '0;
            fused_off          <= '0;
            ofm_cnt            <= '0;
            ofm_off            <= '0;
            ifm_wr_cnt         <= '0;
        end else begin
            bus.rd_en_global <= 1'b0;
            bus.we_global    <= 1'b0;
            bus.done         <= 1'b0;
            tag_addr         <= '0;
            tag_oh           <= '0;

            if (bus.we_fused[NB-1]) begin
                ifm_wr_cnt <= ifm_wr_cnt + ONE;
                if (ifm_wr_cnt == FILL_A - ONE) bus.compute_en <= 1'b1;
            end

            if ((state == STREAM_IFM || state == DRAIN) && bus.valid_layer2 && ofm_cnt != no) begin
                bus.we_global      <= 1'b1;
                bus.wr_addr_global <= base_ofm + ofm_off;
                ofm_off            <= ofm_off + WB;
                ofm_cnt            <= ofm_cnt + ONE;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        base_ifm       <= bus.base_addr_IFM;
                        base_w1        <= bus.base_addr_W1;
                        base_w2        <= bus.base_addr_W2;
                        base_ofm       <= bus.base_addr_OFM;
                        w1pb           <= bus.size_W1 / DIV_W1;
                        w2pb           <= bus.size_W2 / DIV_W2;
                        ni             <= bus.size_IFM / WB;
                        no             <= bus.size_OFM / WB;
                        word_cnt       <= '0;
                        bank_cnt       <= '0;
                        rd_off         <= '0;
                        fused_off      <= '0;
                        ofm_cnt        <= '0;
                        ofm_off        <= '0;
                        ifm_wr_cnt     <= '0;
                        bus.compute_en <= 1'b0;
                        bus.busy       <= 1'b1;
                        state          <= LOAD_W1;
                    end
                end
                LOAD_W1, LOAD_W2, STREAM_IFM: begin
                    if (cur_pw != '0) begin
                        bus.rd_en_global   <= 1'b1;
                        bus.rd_addr_global <= cur_base + rd_off;
                        tag_addr           <= fused_off;
                        tag_oh             <= NB'(1) << (cur_bank0 + bank_cnt);
                    end
                    if (phase_end) begin
                        word_cnt  <= '0;
                        bank_cnt  <= '0;
                        rd_off    <= '0;
                        fused_off <= '0;
                        state     <= cur_next;
                        // Too few IFM words to ever reach the fill mark: enable on drain entry.
                        if (state == STREAM_IFM && ni < FILL_A) bus.compute_en <= 1'b1;
                    end else if (word_cnt == cur_pw - ONE) begin
                        word_cnt  <= '0;
                        fused_off <= '0;
                        bank_cnt  <= bank_cnt + ONE;
                        rd_off    <= rd_off + WB;
                    end else begin
                        word_cnt  <= word_cnt + ONE;
                        fused_off <= fused_off + WB;
                        rd_off    <= rd_off + WB;
                    end
                end
                DRAIN: begin
                    if (ofm_cnt == no && !pending) begin
                        bus.done       <= 1'b1;
                        bus.busy       <= 1'b0;
                        bus.compute_en <= 1'b0;
                        state          <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fused_block_ctrl_param.sv
// Bench for fused_block_ctrl_param: RD_LAT=1 and RD_LAT=3 instances run the same job table side by side.
// A model pushes expected reads/fused writes at start and OFM writes per valid pulse; a monitor pops them.
module tb_fused_block_ctrl_param;
    localparam int AW = 32, L1 = 4, L2 = 2, NB = L1 + L2 + 1, FILL = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0, valid_layer2 = 1'b0;
    logic [AW-1:0] b_ifm = '0, b_w1 = '0, b_w2 = '0, b_ofm = '0;
    logic [AW-1:0] s_ifm = '0, s_w1 = '0, s_w2 = '0, s_ofm = '0;

    fused_block_ctrl_param_if #(.ADDR_W(AW), .N_BANK_L1(L1), .N_BANK_L2(L2)) ifa ();
    fused_block_ctrl_param_if #(.ADDR_W(AW), .N_BANK_L1(L1), .N_BANK_L2(L2)) ifb ();

    fused_block_ctrl_param #(.ADDR_W(AW), .WORD_BYTES(4), .N_BANK_L1(L1), .N_BANK_L2(L2),
        .RD_LAT(1), .FILL_WORDS(FILL)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa.master));
    fused_block_ctrl_param #(.ADDR_W(AW), .WORD_BYTES(4), .N_BANK_L1(L1), .N_BANK_L2(L2),
        .RD_LAT(3), .FILL_WORDS(FILL)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb.master));

    assign ifa.start = start;          assign ifb.start = start;
    assign ifa.valid_layer2 = valid_layer2; assign ifb.valid_layer2 = valid_layer2;
    assign ifa.base_addr_IFM = b_ifm;  assign ifb.base_addr_IFM = b_ifm;
    assign ifa.base_addr_W1 = b_w1;    assign ifb.base_addr_W1 = b_w1;
    assign ifa.base_addr_W2 = b_w2;    assign ifb.base_addr_W2 = b_w2;
    assign ifa.base_addr_OFM = b_ofm;  assign ifb.base_addr_OFM = b_ofm;
    assign ifa.size_IFM = s_ifm;       assign ifb.size_IFM = s_ifm;
    assign ifa.size_W1 = s_w1;         assign ifb.size_W1 = s_w1;
    assign ifa.size_W2 = s_w2;         assign ifb.size_W2 = s_w2;
    assign ifa.size_OFM = s_ofm;       assign ifb.size_OFM = s_ofm;

    logic [NB-1:0] o_wf [2];
    logic [AW-1:0] o_wfa [2], o_rda [2], o_wga [2];
    logic          o_rd [2], o_wg [2], o_busy [2], o_done [2], o_ce [2];
    assign o_wf[0] = ifa.we_fused;        assign o_wf[1] = ifb.we_fused;
    assign o_wfa[0] = ifa.wr_addr_fused;  assign o_wfa[1] = ifb.wr_addr_fused;
    assign o_rda[0] = ifa.rd_addr_global; assign o_rda[1] = ifb.rd_addr_global;
    assign o_wga[0] = ifa.wr_addr_global; assign o_wga[1] = ifb.wr_addr_global;
    assign o_rd[0] = ifa.rd_en_global;    assign o_rd[1] = ifb.rd_en_global;
    assign o_wg[0] = ifa.we_global;       assign o_wg[1] = ifb.we_global;
    assign o_busy[0] = ifa.busy;          assign o_busy[1] = ifb.busy;
    assign o_done[0] = ifa.done;          assign o_done[1] = ifb.done;
    assign o_ce[0] = ifa.compute_en;      assign o_ce[1] = ifb.compute_en;

    typedef struct {
        logic [AW-1:0] b_ifm, b_w1, b_w2, b_ofm;
        logic [AW-1:0] s_ifm, s_w1, s_w2, s_ofm;
        int            extra_pulses;
        bit            mid_start;
        bit            idle_pulse;
        int            exp_fw;
        int            exp_og;
    } vec_t;
    vec_t vecs [6];

    logic [NB+AW-1:0] q_fw [2][$];
    logic [AW-1:0]    q_rd [2][$];
    logic [AW-1:0]    q_og [2][$];

    int checks = 0, errors = 0, cyc = 0, cur_ni = 0;
    int lat [2];
    int first_rd [2], first_wr [2], fw_cnt [2], og_cnt [2], done_cnt [2], ifm_seen [2];
    bit ce_seen [2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [8:0] out_flags(input int d);
        return {o_busy[d], o_done[d], o_ce[d], o_rd[d], o_wg[d],
                |o_wf[d], |o_rda[d], |o_wga[d], |o_wfa[d]};
    endfunction

    task automatic monitor();
        for (int d = 0; d < 2; d++) begin
            if (o_rd[d]) begin
                if (first_rd[d] < 0) first_rd[d] = cyc;
                chk("rd_expected", 64'(q_rd[d].size() != 0), 64'(1));
                if (q_rd[d].size() != 0) chk("rd_addr", 64'(o_rda[d]), 64'(q_rd[d].pop_front()));
            end
            if (o_wf[d] != '0) begin
                fw_cnt[d]++;
                if (o_wf[d][NB-1]) ifm_seen[d]++;
                if (first_wr[d] < 0) begin
                    first_wr[d] = cyc;
                    chk("wr_latency", 64'(cyc - first_rd[d]), 64'(lat[d]));
                end
                chk("fw_expected", 64'(q_fw[d].size() != 0), 64'(1));
                if (q_fw[d].size() != 0)
                    chk("fused_write", 64'({o_wf[d], o_wfa[d]}), 64'(q_fw[d].pop_front()));
            end
            if (o_wg[d]) begin
                og_cnt[d]++;
                chk("og_expected", 64'(q_og[d].size() != 0), 64'(1));
                if (q_og[d].size() != 0) chk("ofm_addr", 64'(o_wga[d]), 64'(q_og[d].pop_front()));
            end
            if (o_ce[d] && !ce_seen[d]) begin
                ce_seen[d] = 1'b1;
                if (cur_ni >= FILL) chk("ce_after_fill", 64'(ifm_seen[d] >= FILL), 64'(1));
            end
            if (o_done[d]) begin
                done_cnt[d]++;
                chk("done_outputs", 64'(out_flags(d) & 9'b101111000), 64'(0));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic clear_job();
        for (int d = 0; d < 2; d++) begin
            first_rd[d] = -1; first_wr[d] = -1; fw_cnt[d] = 0; og_cnt[d] = 0;
            done_cnt[d] = 0; ifm_seen[d] = 0; ce_seen[d] = 1'b0;
            q_fw[d].delete(); q_rd[d].delete(); q_og[d].delete();
        end
    endtask

    // Model of the contiguous read stream and the per-bank fused write order.
    task automatic load_job(input vec_t v);
        int w1pb, w2pb, ni;
        b_ifm = v.b_ifm; b_w1 = v.b_w1; b_w2 = v.b_w2; b_ofm = v.b_ofm;
        s_ifm = v.s_ifm; s_w1 = v.s_w1; s_w2 = v.s_w2; s_ofm = v.s_ofm;
        w1pb = int'(v.s_w1 / 32'(4 * L1));
        w2pb = int'(v.s_w2 / 32'(4 * L2));
        ni   = int'(v.s_ifm / 32'd4);
        cur_ni = ni;
        clear_job();
        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < L1; b++)
                for (int w = 0; w < w1pb; w++) begin
                    q_rd[d].push_back(v.b_w1 + AW'((b * w1pb + w) * 4));
                    q_fw[d].push_back({NB'(1) << b, AW'(w * 4)});
                end
            for (int b = 0; b < L2; b++)
                for (int w = 0; w < w2pb; w++) begin
                    q_rd[d].push_back(v.b_w2 + AW'((b * w2pb + w) * 4));
                    q_fw[d].push_back({NB'(1) << (L1 + b), AW'(w * 4)});
                end
            for (int w = 0; w < ni; w++) begin
                q_rd[d].push_back(v.b_ifm + AW'(w * 4));
                q_fw[d].push_back({NB'(1) << (NB - 1), AW'(w * 4)});
            end
        end
    endtask

    task automatic run_job(input vec_t v);
        int n, no;
        no = int'(v.s_ofm / 32'd4);
        if (v.idle_pulse) begin
            clear_job();
            valid_layer2 = 1'b1; tick(); valid_layer2 = 1'b0; tick();
        end
        load_job(v);
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!(ce_seen[0] && ce_seen[1]) && n < 2000) begin tick(); n++; end
        chk("ce_timeout", 64'(ce_seen[0] && ce_seen[1]), 64'(1));
        if (v.mid_start) begin start = 1'b1; tick(); start = 1'b0; end
        for (int p = 0; p < no + v.extra_pulses; p++) begin
            valid_layer2 = 1'b1;
            if (p < no) for (int d = 0; d < 2; d++) q_og[d].push_back(v.b_ofm + AW'(p * 4));
            tick();
            valid_layer2 = 1'b0;
            tick();
        end
        n = 0;
        while (!(done_cnt[0] > 0 && done_cnt[1] > 0) && n < 2000) begin tick(); n++; end
        chk("done_timeout", 64'(done_cnt[0] > 0 && done_cnt[1] > 0), 64'(1));
        repeat (4) tick();
        for (int d = 0; d < 2; d++) begin
            chk("done_count", 64'(done_cnt[d]), 64'(1));
            chk("fw_count", 64'(fw_cnt[d]), 64'(v.exp_fw));
            chk("og_count", 64'(og_cnt[d]), 64'(v.exp_og));
            chk("queues_empty", 64'(q_fw[d].size() + q_rd[d].size() + q_og[d].size()), 64'(0));
            chk("idle_busy", 64'(o_busy[d]), 64'(0));
        end
    endtask

    initial begin
        lat[0] = 1; lat[1] = 3;
        // b_ifm, b_w1, b_w2, b_ofm, s_ifm, s_w1, s_w2, s_ofm, extra, mid_start, idle_pulse, exp_fw, exp_og
        vecs[0] = '{32'h400, 32'h100, 32'h200, 32'h800, 32'd32, 32'd64, 32'd16, 32'd8, 0, 1'b0, 1'b0, 28, 2};
        vecs[1] = '{32'h400, 32'h100, 32'h200, 32'h800, 32'd8,  32'd64, 32'd0,  32'd8, 0, 1'b0, 1'b0, 18, 2};
        vecs[2] = '{32'h400, 32'h100, 32'h200, 32'h800, 32'd32, 32'd64, 32'd16, 32'd8, 2, 1'b1, 1'b1, 28, 2};
        vecs[3] = '{32'h400, 32'h100, 32'h200, 32'h800, 32'd14, 32'd70, 32'd12, 32'd12, 0, 1'b0, 1'b0, 21, 3};
        vecs[4] = '{32'h400, 32'h100, 32'h200, 32'h800, 32'd0,  32'd0,  32'd0,  32'd4, 0, 1'b0, 1'b0, 0, 1};
        vecs[5] = '{32'h40, 32'hFFFF_FFF8, 32'h300, 32'hFFFF_FFFC, 32'd12, 32'd32, 32'd8, 32'd8, 0, 1'b0, 1'b0, 13, 2};

        clear_job();
        repeat (3) tick();
        for (int d = 0; d < 2; d++) chk("reset_outputs", 64'(out_flags(d)), 64'(0));
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) run_job(vecs[i]);

        // Reset in the middle of LOAD_W1, then the same job must start over from base_W1/bank0.
        load_job(vecs[0]);
        start = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
        chk("mid_busy", 64'(o_busy[0] && o_busy[1] && o_rd[0] && o_rd[1]), 64'(1));
        reset_n = 1'b0;
        tick();
        for (int d = 0; d < 2; d++) chk("mid_reset_outputs", 64'(out_flags(d)), 64'(0));
        reset_n = 1'b1;
        clear_job();
        tick();
        run_job(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
